// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory access types, FSM states and access size helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 marks an illegal type encoding.
    function automatic logic [2:0] size_of(input mem_type_e t);
        case (t)
            MT_B, MT_BU: size_of = 3'd1;
            MT_H, MT_HU: size_of = 3'd2;
            MT_W:        size_of = 3'd4;
            default:     size_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/strobe shifter over a word pair and load extractor
// that pulls the addressed bytes out of a word pair and sign- or zero-extends them.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] st_wdata,
    input  logic [2:0]  st_type,
    input  logic [1:0]  st_offset,
    output logic [63:0] st_data,
    output logic [7:0]  st_be,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);

    logic [2:0]  st_size;
    logic [3:0]  size_mask;
    logic [31:0] ld_word;

    assign st_size = size_of(mem_type_e'(st_type));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_size_mask
            assign size_mask[gi] = (3'(gi) < st_size);
        end
    endgenerate

    // Low half of the shifted pair goes to the first word, high half to the next word.
    assign st_data = {32'b0, st_wdata} << {st_offset, 3'b000};
    assign st_be   = {4'b0, size_mask} << st_offset;

    assign ld_word = 32'({ld_hi, ld_lo} >> {ld_offset, 3'b000});

    always_comb begin
        ld_data = '0;
        case (ld_type)
            MT_B:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            MT_H:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            MT_W:    ld_data = ld_word;
            MT_BU:   ld_data = {24'b0, ld_word[7:0]};
            MT_HU:   ld_data = {16'b0, ld_word[15:0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller: byte-addressed requests in, word accesses with byte enables out.
// Define LSU_MISALIGN_EN to execute word-crossing accesses as two word accesses; otherwise they fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_mem_type,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-3:0] address,
    output logic [31:0]       write_data,
    output logic [3:0]        byte_en,
    output logic              write_enable,
    output logic              read_enable,
    input  logic [31:0]       read_data
);

    lsu_state_e  state_reg;
    logic        write_reg;
    logic [2:0]  type_reg;
    logic [1:0]  offset_reg;
    logic        fault_reg;

    logic [63:0] st_data;
    logic [7:0]  st_be;
    logic [31:0] ld_data;
    logic [31:0] ld_lo;
    logic [2:0]  req_size;
    logic        req_split;
    logic        req_fault;

    assign req_size  = size_of(mem_type_e'(req_mem_type));
    assign req_split = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;

`ifdef LSU_MISALIGN_EN
    logic              split_reg;
    logic [ADDR_W-3:0] word_addr_reg;
    logic [31:0]       st_hi_data_reg;
    logic [3:0]        st_hi_be_reg;
    logic [31:0]       word0_reg;

    // A split access may not wrap from the last word back to word 0.
    assign req_fault = (req_mem_type inside {3'b011, 3'b110, 3'b111})
                     || (req_write && req_mem_type[2])
                     || (req_split && (&req_addr[ADDR_W-1:2]));
    assign ld_lo = split_reg ? word0_reg : read_data;
`else
    logic unused_hi;

    assign req_fault = (req_mem_type inside {3'b011, 3'b110, 3'b111})
                     || (req_write && req_mem_type[2])
                     || req_split;
    assign ld_lo     = read_data;
    assign unused_hi = ^{st_data[63:32], st_be[7:4]};
`endif

    lsu_lane_align u_lane_align (
        .st_wdata  (req_wdata),
        .st_type   (req_mem_type),
        .st_offset (req_addr[1:0]),
        .st_data   (st_data),
        .st_be     (st_be),
        .ld_type   (type_reg),
        .ld_offset (offset_reg),
        .ld_lo     (ld_lo),
        .ld_hi     (read_data),
        .ld_data   (ld_data)
    );

    // read_data for the final (or only) word arrives in RESP, so the load result stays combinational.
    assign rsp_rdata = (state_reg == RESP && !write_reg && !fault_reg) ? ld_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_fault      <= 1'b0;
            address        <= '0;
            write_data     <= '0;
            byte_en        <= '0;
            write_enable   <= 1'b0;
            read_enable    <= 1'b0;
            write_reg      <= 1'b0;
            type_reg       <= '0;
            offset_reg     <= '0;
            fault_reg      <= 1'b0;
`ifdef LSU_MISALIGN_EN
            split_reg      <= 1'b0;
            word_addr_reg  <= '0;
            st_hi_data_reg <= '0;
            st_hi_be_reg   <= '0;
            word0_reg      <= '0;
`endif
        end else begin
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            byte_en      <= '0;
            write_data   <= '0;
            rsp_valid    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        state_reg  <= ACC0;
                        req_ready  <= 1'b0;
                        write_reg  <= req_write;
                        type_reg   <= req_mem_type;
                        offset_reg <= req_addr[1:0];
                        fault_reg  <= req_fault;
`ifdef LSU_MISALIGN_EN
                        split_reg      <= req_split;
                        word_addr_reg  <= req_addr[ADDR_W-1:2];
                        st_hi_data_reg <= st_data[63:32];
                        st_hi_be_reg   <= st_be[7:4];
`endif
                        // First-word strobes are registered here so they appear in ACC0.
                        if (!req_fault) begin
                            address <= req_addr[ADDR_W-1:2];
                            if (req_write) begin
                                write_enable <= 1'b1;
                                byte_en      <= st_be[3:0];
                                write_data   <= st_data[31:0];
                            end else begin
                                read_enable <= 1'b1;
                            end
                        end
                    end
                end
                ACC0: begin
`ifdef LSU_MISALIGN_EN
                    if (split_reg && !fault_reg) begin
                        state_reg <= ACC1;
                        address   <= word_addr_reg + (ADDR_W-2)'(1);
                        if (write_reg) begin
                            write_enable <= 1'b1;
                            byte_en      <= st_hi_be_reg;
                            write_data   <= st_hi_data_reg;
                        end else begin
                            read_enable <= 1'b1;
                        end
                    end else
`endif
                    begin
                        state_reg <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= fault_reg;
                    end
                end
`ifdef LSU_MISALIGN_EN
                ACC1: begin
                    word0_reg <= read_data;
                    state_reg <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_fault <= fault_reg;
                end
`endif
                RESP: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                    rsp_fault <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word byte-enabled memory model.
// Expectations follow LSU_MISALIGN_EN when it is defined for the build.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_mem_type;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic [ADDR_W-3:0] address;
    logic [31:0]       write_data;
    logic [3:0]        byte_en;
    logic              write_enable;
    logic              read_enable;
    logic [31:0]       read_data;

    logic [31:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    int checks = 0;
    int errors = 0;

    logic        we_c [1:4];
    logic        re_c [1:4];
    logic        rv_c [1:4];
    logic        ft_c [1:4];
    logic [3:0]  ad_c [1:4];
    logic [3:0]  be_c [1:4];
    logic [31:0] wd_c [1:4];
    logic [31:0] rd_c [1:4];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_mem_type (req_mem_type),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .address      (address),
        .write_data   (write_data),
        .byte_en      (byte_en),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data)
    );

    // Memory model: registered read, per-byte write, plus a bench-side preset port.
    always @(posedge clk) begin
        if (read_enable)
            read_data <= mem[address];
        if (write_enable)
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[address][8*b +: 8] <= write_data[8*b +: 8];
        if (pre_en)
            mem[pre_idx] <= pre_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic [3:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request and records outputs for cycles T+1..T+4.
    task automatic do_req(input logic wr, input logic [5:0] a, input logic [31:0] wd, input logic [2:0] mt);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_write    = wr;
        req_addr     = a;
        req_wdata    = wd;
        req_mem_type = mt;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = 6'h00;
        req_wdata    = 32'h5A5A5A5A;
        req_mem_type = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            we_c[k] = write_enable;
            re_c[k] = read_enable;
            rv_c[k] = rsp_valid;
            ft_c[k] = rsp_fault;
            ad_c[k] = address;
            be_c[k] = byte_en;
            wd_c[k] = write_data;
            rd_c[k] = rsp_rdata;
        end
        $display("txn wr=%0b addr=0x%02h wdata=0x%08h type=%03b -> rv=%0b%0b%0b fault=%0b%0b%0b rdata=0x%08h/0x%08h",
                 wr, a, wd, mt, rv_c[1], rv_c[2], rv_c[3], ft_c[1], ft_c[2], ft_c[3], rd_c[2], rd_c[3]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_mem_type = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_write_enable", {31'b0, write_enable}, 32'd0);
        check("rst_read_enable", {31'b0, read_enable}, 32'd0);
        check("rst_byte_en", {28'b0, byte_en}, 32'd0);
        check("rst_address", {28'b0, address}, 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Aligned SW
        set_mem(4'd1, 32'h0);
        do_req(1'b1, 6'h04, 32'hDEADBEEF, MT_W);
        check("sw_we_t1", {31'b0, we_c[1]}, 32'd1);
        check("sw_addr_t1", {28'b0, ad_c[1]}, 32'd1);
        check("sw_be_t1", {28'b0, be_c[1]}, 32'hF);
        check("sw_wd_t1", wd_c[1], 32'hDEADBEEF);
        check("sw_rv_t1", {31'b0, rv_c[1]}, 32'd0);
        check("sw_rv_t2", {31'b0, rv_c[2]}, 32'd1);
        check("sw_fault_t2", {31'b0, ft_c[2]}, 32'd0);
        check("sw_we_t2", {31'b0, we_c[2]}, 32'd0);
        check("sw_mem1", mem[1], 32'hDEADBEEF);

        // LB / LBU from the top byte of word 1
        set_mem(4'd1, 32'h80000000);
        do_req(1'b0, 6'h07, 32'h0, MT_B);
        check("lb_re_t1", {31'b0, re_c[1]}, 32'd1);
        check("lb_addr_t1", {28'b0, ad_c[1]}, 32'd1);
        check("lb_rv_t2", {31'b0, rv_c[2]}, 32'd1);
        check("lb_rdata", rd_c[2], 32'hFFFFFF80);
        do_req(1'b0, 6'h07, 32'h0, MT_BU);
        check("lbu_rdata", rd_c[2], 32'h00000080);

        // SH into the middle lanes
        set_mem(4'd1, 32'hAABBCCDD);
        do_req(1'b1, 6'h05, 32'h00001234, MT_H);
        check("sh_addr_t1", {28'b0, ad_c[1]}, 32'd1);
        check("sh_be_t1", {28'b0, be_c[1]}, 32'b0110);
        check("sh_wd_t1", wd_c[1], 32'h00123400);
        check("sh_mem1", mem[1], 32'hAA1234DD);
        check("sh_rdata_zero", rd_c[2], 32'h0);

        // LH sign extension from lanes 2..3
        set_mem(4'd3, 32'h9ABC0000);
        do_req(1'b0, 6'h0E, 32'h0, MT_H);
        check("lh_rdata", rd_c[2], 32'hFFFF9ABC);
        do_req(1'b0, 6'h0E, 32'h0, MT_HU);
        check("lhu_rdata", rd_c[2], 32'h00009ABC);

        // Split LW across words 1 and 2
        set_mem(4'd1, 32'h44332211);
        set_mem(4'd2, 32'h88776655);
        do_req(1'b0, 6'h06, 32'h0, MT_W);
`ifdef LSU_MISALIGN_EN
        check("slw_re_t1", {31'b0, re_c[1]}, 32'd1);
        check("slw_addr_t1", {28'b0, ad_c[1]}, 32'd1);
        check("slw_re_t2", {31'b0, re_c[2]}, 32'd1);
        check("slw_addr_t2", {28'b0, ad_c[2]}, 32'd2);
        check("slw_rv_t2", {31'b0, rv_c[2]}, 32'd0);
        check("slw_rv_t3", {31'b0, rv_c[3]}, 32'd1);
        check("slw_fault_t3", {31'b0, ft_c[3]}, 32'd0);
        check("slw_rdata_t3", rd_c[3], 32'h66554433);
`else
        check("slw_re_t1", {31'b0, re_c[1]}, 32'd0);
        check("slw_re_t2", {31'b0, re_c[2]}, 32'd0);
        check("slw_rv_t2", {31'b0, rv_c[2]}, 32'd1);
        check("slw_fault_t2", {31'b0, ft_c[2]}, 32'd1);
        check("slw_rdata_t2", rd_c[2], 32'h0);
`endif

        // Split SW across words 1 and 2
        set_mem(4'd1, 32'h0);
        set_mem(4'd2, 32'h0);
        do_req(1'b1, 6'h06, 32'hCAFEBABE, MT_W);
`ifdef LSU_MISALIGN_EN
        check("ssw_be_t1", {28'b0, be_c[1]}, 32'b1100);
        check("ssw_wd_t1", wd_c[1], 32'hBABE0000);
        check("ssw_addr_t2", {28'b0, ad_c[2]}, 32'd2);
        check("ssw_be_t2", {28'b0, be_c[2]}, 32'b0011);
        check("ssw_wd_t2", wd_c[2], 32'h0000CAFE);
        check("ssw_rv_t3", {31'b0, rv_c[3]}, 32'd1);
        check("ssw_mem1", mem[1], 32'hBABE0000);
        check("ssw_mem2", mem[2], 32'h0000CAFE);
`else
        check("ssw_we_t1", {31'b0, we_c[1]}, 32'd0);
        check("ssw_fault_t2", {31'b0, ft_c[2]}, 32'd1);
        check("ssw_mem1", mem[1], 32'h0);
`endif

        // Split at the last word: faults in both builds
        do_req(1'b0, 6'h3E, 32'h0, MT_W);
        check("wrap_re_t1", {31'b0, re_c[1]}, 32'd0);
        check("wrap_re_t2", {31'b0, re_c[2]}, 32'd0);
        check("wrap_rv_t2", {31'b0, rv_c[2]}, 32'd1);
        check("wrap_fault_t2", {31'b0, ft_c[2]}, 32'd1);

        // Illegal type 011 and unsigned store
        do_req(1'b0, 6'h00, 32'h0, 3'b011);
        check("ill_re_t1", {31'b0, re_c[1]}, 32'd0);
        check("ill_fault_t2", {31'b0, ft_c[2]}, 32'd1);
        set_mem(4'd4, 32'h01020304);
        do_req(1'b1, 6'h10, 32'hFFFFFFFF, MT_BU);
        check("sbu_we_t1", {31'b0, we_c[1]}, 32'd0);
        check("sbu_fault_t2", {31'b0, ft_c[2]}, 32'd1);
        check("sbu_mem4", mem[4], 32'h01020304);

        // Split SW with reset asserted in T+2
        set_mem(4'd1, 32'h0);
        set_mem(4'd2, 32'h11111111);
        req_write    = 1'b1;
        req_addr     = 6'h06;
        req_wdata    = 32'hCAFEBABE;
        req_mem_type = MT_W;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`ifdef LSU_MISALIGN_EN
        check("rstop_we_t1", {31'b0, write_enable}, 32'd1);
`else
        check("rstop_we_t1", {31'b0, write_enable}, 32'd0);
`endif
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstop_we_t2", {31'b0, write_enable}, 32'd0);
        check("rstop_rv_t2", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rstop_mem2", mem[2], 32'h11111111);
`ifdef LSU_MISALIGN_EN
        check("rstop_mem1", mem[1], 32'hBABE0000);
`else
        check("rstop_mem1", mem[1], 32'h0);
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstop_no_rv", {31'b0, rsp_valid}, 32'd0);
        end
        check("rstop_ready", {31'b0, req_ready}, 32'd1);
        $display("txn reset during split SW: mem1=0x%08h mem2=0x%08h", mem[1], mem[2]);

        // Operation resumes after the abort
        do_req(1'b0, 6'h08, 32'h0, MT_W);
        check("resume_rdata", rd_c[2], 32'h11111111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store controller sitting between the core's execute stage and `DATA_MEMORY`. Accepts byte-addressed load/store requests over a valid/ready handshake, turns them into word-addressed memory accesses with byte enables, splits misaligned accesses into two word accesses, and returns sign- or zero-extended load data or a store acknowledge. Stalls the core via `req_ready` while an access is in flight.

## Interface
- `ADDR_W`, 6, byte-address width; the word address is `ADDR_W-2` bits (4 bits, 16 words, by default)
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-high
- `req_valid` in 1, request present
- `req_ready` out 1, high only in IDLE
- `req_write` in 1, 1 = store, 0 = load
- `req_addr` in `ADDR_W`, byte address
- `req_wdata` in 32, store data, right-justified
- `req_mem_type` in 3, 000 B, 001 H, 010 W, 100 BU, 101 HU
- `rsp_valid` out 1, one-cycle completion pulse
- `rsp_rdata` out 32, extended load data; 0 for stores and faults
- `rsp_fault` out 1, qualified by `rsp_valid`
- `address` out `ADDR_W-2`, word address to memory
- `write_data` out 32, lane-positioned store word
- `byte_en` out 4, per-lane write enables
- `write_enable` out 1, memory write strobe
- `read_enable` out 1, memory read strobe
- `read_data` in 32, memory word; valid the cycle after `read_enable`

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid && req_ready`) latches write, addr, wdata, type and offset = addr[1:0], then goes to ACC0.
- Split condition: offset + size > 4, where size is 1/2/4 for B/H/W.
- Fault conditions, checked at accept:
  - illegal type (011, 110, 111);
  - store with type 100 or 101;
  - split access with `MISALIGN_EN` undefined;
  - split access whose first word is the last word (no wrap-around).
- Faulted requests go ACC0 to RESP with no memory strobe asserted.
- ACC0 drives the first word, `addr[ADDR_W-1:2]`.
  - Store: `write_enable`=1, `byte_en` and `write_data` are the low half of the 64-bit lane-shift, wdata << 8*offset.
  - Load: `read_enable`=1.
  - Next state is ACC1 if split, otherwise RESP.
- ACC1 drives word+1 with the upper half of the lane-shift. For loads it also captures the word-0 read data.
- RESP: `rsp_valid`=1. Loads form {word1, word0} >> 8*offset, truncate to size, then sign-extend (000/001) or zero-extend (100/101); W is passed through. Next state is IDLE.
- Strobes are deasserted outside ACC0/ACC1. `byte_en` is 0 whenever `write_enable` is 0.

## Timing
- Handshake at cycle T.
  - Aligned access: memory strobe at T+1, `rsp_valid` at T+2.
  - Split access: strobes at T+1 and T+2, `rsp_valid` at T+3.
  - Faulted access: `rsp_valid` at T+2, no strobes.
- The next request is accepted no earlier than the cycle after RESP.
- `req_*` inputs are ignored when `req_ready`=0.
- Reset values: state IDLE; `req_ready`=1; all other outputs 0.
- Reset asserted mid-operation: the FSM aborts to IDLE immediately, with no `rsp_valid`. Words already written stay written; a pending second store half is not issued.

## Configuration
- `LSU_MISALIGN_EN` defined: split accesses are executed as two word accesses, as described above.
- `LSU_MISALIGN_EN` undefined: any split access faults (`rsp_fault`=1 at T+2) and no memory strobe is asserted. The ACC1 logic and the word-0 capture register are not synthesised.

## Structure
- `lsu_pkg` holds:
  - `mem_type_e` enum (MT_B=000, MT_H=001, MT_W=010, MT_BU=100, MT_HU=101);
  - `lsu_state_e` enum;
  - a `size_of(mem_type_e)` function.
- The core and the `DATA_MEMORY` testbenches import `lsu_pkg`.
- One combinational sub-module, `lsu_lane_align`, contains:
  - the store shifter (64-bit data and 8-bit strobe from wdata/type/offset);
  - the load extractor (64-bit word pair to extended 32-bit result).

## Test plan
- Aligned SW addr 0x04, wdata 0xDEADBEEF -> T+1: address=1, byte_en=1111, write_data=0xDEADBEEF; T+2: rsp_valid=1, fault=0.
- LB addr 0x07, memory word1=0x80000000 -> rsp_rdata=0xFFFFFF80 at T+2. LBU at the same address -> 0x00000080.
- SH addr 0x05, wdata 0x1234 -> T+1: address=1, byte_en=0110, write_data=0x00123400.
- With the macro, LW addr 0x06, word1=0x44332211, word2=0x88776655 -> strobes at T+1 (addr 1) and T+2 (addr 2), rsp_rdata=0x66554433 at T+3. Without the macro -> fault at T+2, no strobes.
- Split LW addr 0x3E, and any access with type 011 -> fault=1, no `read_enable` or `write_enable` asserted.
- Split SW issued, reset asserted at T+2 -> second write suppressed, no rsp_valid, `req_ready`=1 after reset releases.
